// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch with PC advance control and a decode-side FIFO
// Ports: CLK/RST (async active-low); PC in, PC_WRITE out; FLUSH redirect in;
//        IMEM_REQ/IMEM_ADDR/IMEM_GNT request side; IMEM_RVALID/IMEM_RDATA in-order responses;
//        ID_VALID/ID_READY/ID_INSTR/ID_PC decode handshake.
// Optional: define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO holds no filled entry.
module fetch_queue #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC,
    output logic        PC_WRITE,
    input  logic        FLUSH,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        ID_VALID,
    input  logic        ID_READY,
    output logic [31:0] ID_INSTR,
    output logic [31:0] ID_PC
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0] filled_cnt_q, filled_cnt_d;
    logic [CW-1:0] discard_cnt_q, discard_cnt_d;
    logic [CW-1:0] unfilled;
    logic [AW-1:0] tail, fill_ptr;
    logic          alloc, fill, drop, pop, head_filled;

    // Entries fill in allocation order, so filled ones always sit contiguously at the head.
    assign unfilled    = alloc_cnt_q - filled_cnt_q;
    assign tail        = head_q + alloc_cnt_q[AW-1:0];
    assign fill_ptr    = head_q + filled_cnt_q[AW-1:0];
    assign head_filled = filled_cnt_q != '0;

    assign IMEM_ADDR = {PC[31:2], 2'b00};
    assign IMEM_REQ  = RST & ~FLUSH & (({1'b0, alloc_cnt_q} + {1'b0, discard_cnt_q}) < DEPTH_C);
    assign alloc     = IMEM_REQ & IMEM_GNT;
    assign PC_WRITE  = RST & (FLUSH | alloc);

    // Responses owed to flushed requests retire first; they are never written.
    assign drop = IMEM_RVALID & (discard_cnt_q != '0);
    assign fill = IMEM_RVALID & ~drop & (unfilled != '0);

`ifdef FETCH_BYPASS_EN
    assign ID_VALID = ~FLUSH & (head_filled | fill);
    assign ID_INSTR = !ID_VALID ? NOP : head_filled ? instr_q[head_q] : IMEM_RDATA;
`else
    assign ID_VALID = ~FLUSH & head_filled;
    assign ID_INSTR = ID_VALID ? instr_q[head_q] : NOP;
`endif
    assign ID_PC = ID_VALID ? pc_q[head_q] : '0;
    assign pop   = ID_VALID & ID_READY;

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        head_d        = head_q;
        alloc_cnt_d   = alloc_cnt_q;
        filled_cnt_d  = filled_cnt_q;
        discard_cnt_d = discard_cnt_q;
        if (alloc) pc_d[tail] = PC;
        if (fill) instr_d[fill_ptr] = IMEM_RDATA;
        if (FLUSH) begin
            // Every unfilled entry still owes a response; one arriving now is already retired.
            alloc_cnt_d   = '0;
            filled_cnt_d  = '0;
            discard_cnt_d = discard_cnt_q + unfilled - CW'(drop | fill);
        end else begin
            head_d        = head_q + AW'(pop);
            alloc_cnt_d   = alloc_cnt_q + CW'(alloc) - CW'(pop);
            filled_cnt_d  = filled_cnt_q + CW'(fill) - CW'(pop);
            discard_cnt_d = discard_cnt_q - CW'(drop);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q          <= '{default: '0};
            instr_q       <= '{default: '0};
            head_q        <= '0;
            alloc_cnt_q   <= '0;
            filled_cnt_q  <= '0;
            discard_cnt_q <= '0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            head_q        <= head_d;
            alloc_cnt_q   <= alloc_cnt_d;
            filled_cnt_q  <= filled_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end
endmodule
